// File: rtl/logic_gate_pkg.sv
// Shared types and helpers for the logic_gate_pipe block: opcode encoding,
// the bitwise gate evaluator and a constant-foldable ceil(log2) helper.
package logic_gate_pkg;

   // Opcode encoding carried alongside every request and result.
   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   // Widest operand the evaluator handles; callers truncate to their WIDTH.
   localparam int MAX_WIDTH = 64;

   // Evaluate one gate over MAX_WIDTH bits. Operands are zero-extended by the
   // caller and the result truncated back, so NAND stays correct over the
   // caller's full width (the extra high bits are simply dropped).
   function automatic logic [MAX_WIDTH-1:0] gate_eval(
      input op_e                  op,
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b
   );
      logic [MAX_WIDTH-1:0] y;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         default: y = {MAX_WIDTH{1'b0}};
      endcase
      return y;
   endfunction

   // Smallest r with 2**r >= n; used to size pointers at elaboration time.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Request/response handshake bundle for logic_gate_pipe.
// master = request producer and result consumer, slave = the pipe itself.
interface logic_gate_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic [1:0]       out_op;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_y, out_op
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_y, out_op
   );
endinterface

// File: rtl/lgp_fifo.sv
// Circular-buffer result FIFO. Wrapping log2(DEPTH)-bit pointers and a
// separate occupancy counter one bit wider so that "full" is representable.
module lgp_fifo
   import logic_gate_pkg::*;
#(
   parameter  int DW    = 10,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic [CW-1:0] count_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          pop_s;
   logic          full_s;

   assign full_s  = (count_q == CW'(DEPTH));
   // A pop request against an empty buffer is ignored rather than underflowing.
   assign pop_s   = pop_i && (count_q != {CW{1'b0}});
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Occupancy next state: simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_i, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   lgp_fifo_chk u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push_i),
      .full_i (full_s)
   );

endmodule

// File: rtl/lgp_fifo_chk.sv
// Property checker for lgp_fifo: the upstream credit scheme must make a
// write into a full FIFO impossible.
module lgp_fifo_chk (
   input logic clk,
   input logic rst_n,
   input logic push_i,
   input logic full_i
);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i));

endmodule

// File: rtl/logic_gate_pipe.sv
// Fixed-latency bitwise gate pipeline with a credit-protected output FIFO.
// The pipeline never stalls; admission is throttled so that every accepted
// request is guaranteed a FIFO slot when it reaches the last stage.
module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   logic_gate_pipe_if.slave   bus,
   output logic [15:0]        resp_count,
   output logic               busy
);

   localparam int DW = WIDTH + 2;
   localparam int CW = clog2(DEPTH) + 1;

   // Pipeline stages: valid bit, result and opcode per stage.
   logic [LATENCY-1:0] vld_q;
   logic [WIDTH-1:0]   y_q  [LATENCY];
   logic [1:0]         op_q [LATENCY];

   // Credits in use = requests in the pipeline plus entries in the FIFO.
   logic [CW-1:0]      used_q;
   logic [CW-1:0]      used_d;
   logic               in_ready_q;
   logic               busy_q;
   logic [15:0]        resp_q;

   logic               accept_s;
   logic               pop_s;
   logic               push_s;
   logic [WIDTH-1:0]   stage0_y_s;
   logic [DW-1:0]      head_s;
   logic [CW-1:0]      fifo_count_s;

   assign accept_s   = bus.in_valid && in_ready_q;
   assign pop_s      = bus.out_valid && bus.out_ready;
   assign push_s     = vld_q[LATENCY-1];
   assign stage0_y_s = WIDTH'(gate_eval(op_e'(bus.in_op), 64'(bus.in_a), 64'(bus.in_b)));

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (fifo_count_s != {CW{1'b0}});
   assign bus.out_y     = head_s[WIDTH-1:0];
   assign bus.out_op    = head_s[WIDTH+1:WIDTH];
   assign resp_count    = resp_q;
   assign busy          = busy_q;

   // Credit bookkeeping: one credit taken per accept, returned per output pop.
   always_comb begin
      used_d = used_q;
      case ({accept_s, pop_s})
         2'b10:   used_d = used_q + CW'(1);
         2'b01:   used_d = used_q - CW'(1);
         default: used_d = used_q;
      endcase
   end

   // Shift register of results; the gate is evaluated as the request enters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= {LATENCY{1'b0}};
         for (int i = 0; i < LATENCY; i++) begin
            y_q[i]  <= {WIDTH{1'b0}};
            op_q[i] <= 2'b00;
         end
      end else begin
         vld_q[0] <= accept_s;
         y_q[0]   <= stage0_y_s;
         op_q[0]  <= bus.in_op;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            y_q[i]   <= y_q[i-1];
            op_q[i]  <= op_q[i-1];
         end
      end
   end

   // Registered admission and status: in_ready only sees registered state, so
   // a credit freed by a pop is visible one cycle later; held low in reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         used_q     <= {CW{1'b0}};
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         used_q     <= used_d;
         in_ready_q <= (used_d < CW'(DEPTH));
         busy_q     <= (used_d != {CW{1'b0}});
      end
   end

   // Completed output handshakes, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_q <= 16'd0;
      end else if (pop_s) begin
         resp_q <= resp_q + 16'd1;
      end else begin
         resp_q <= resp_q;
      end
   end

   lgp_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .data_i  ({op_q[LATENCY-1], y_q[LATENCY-1]}),
      .pop_i   (pop_s),
      .data_o  (head_s),
      .count_o (fifo_count_s)
   );

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe (WIDTH=8, LATENCY=2, DEPTH=4).
// A transaction-level model holds accepted-but-unconsumed results in a queue
// with the cycle at which each becomes visible; every cycle the DUT outputs
// are compared against it.
module tb_logic_gate_pipe;

   localparam int WIDTH   = 8;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] resp_count;
   logic        busy;

   logic_gate_pipe_if #(.WIDTH(WIDTH)) bus ();

   logic_gate_pipe #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .resp_count (resp_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] y;
      logic [1:0] op;
      int         vis;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
   } vec_t;

   exp_t        model_q [$];
   logic [9:0]  got_q   [$];
   logic [15:0] resp_exp;
   int          cyc;
   int          acc_cnt;
   int          errors;
   int          checks;

   function automatic logic [7:0] ref_gate(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic ordy);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_op     = op;
      bus.out_ready = ordy;
   endtask

   task automatic drive_rand(input logic v, input logic ordy);
      drive(v, 8'($urandom), 8'($urandom), 2'($urandom), ordy);
   endtask

   // One clock: check outputs against the model, observe handshakes, advance the model.
   task automatic step();
      logic       acc;
      logic       pp;
      logic       ev;
      logic [7:0] y_s;
      logic [1:0] op_s;
      exp_t       e;
      @(negedge clk);
      ev = (model_q.size() != 0) && (model_q[0].vis <= cyc);
      check("out_valid", 64'(bus.out_valid), 64'(ev));
      if (ev) begin
         check("out_y", 64'(bus.out_y), 64'(model_q[0].y));
         check("out_op", 64'(bus.out_op), 64'(model_q[0].op));
      end
      check("in_ready", 64'(bus.in_ready), 64'(model_q.size() < DEPTH));
      check("busy", 64'(busy), 64'(model_q.size() != 0));
      check("resp_count", 64'(resp_count), 64'(resp_exp));
      acc    = bus.in_valid && bus.in_ready;
      pp     = bus.out_valid && bus.out_ready;
      y_s    = bus.out_y;
      op_s   = bus.out_op;
      e.y    = ref_gate(bus.in_op, bus.in_a, bus.in_b);
      e.op   = bus.in_op;
      @(posedge clk);
      cyc++;
      if (pp) begin
         got_q.push_back({op_s, y_s});
         if (model_q.size() != 0) begin
            void'(model_q.pop_front());
         end
         resp_exp++;
      end
      if (acc) begin
         e.vis = cyc + LATENCY;
         model_q.push_back(e);
         acc_cnt++;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      model_q.delete();
      resp_exp = 16'd0;
      check("rst in_ready", 64'(bus.in_ready), 64'd0);
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst out_y", 64'(bus.out_y), 64'd0);
      check("rst out_op", 64'(bus.out_op), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst resp_count", 64'(resp_count), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post-rst in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic drain(input string name);
      drive(1'b0, 8'd0, 8'd0, 2'd0, 1'b1);
      for (int i = 0; i < 50 && model_q.size() != 0; i++) begin
         step();
      end
      check(name, 64'(model_q.size()), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec [4];
      errors   = 0;
      checks   = 0;
      cyc      = 0;
      acc_cnt  = 0;
      resp_exp = 16'd0;
      drive(1'b0, 8'd0, 8'd0, 2'd0, 1'b0);

      vec[0] = '{op: 2'b00, a: 8'hF0, b: 8'h3C, y: 8'h30};
      vec[1] = '{op: 2'b01, a: 8'hF0, b: 8'h3C, y: 8'hFC};
      vec[2] = '{op: 2'b10, a: 8'hF0, b: 8'h3C, y: 8'hCC};
      vec[3] = '{op: 2'b11, a: 8'hF0, b: 8'h3C, y: 8'hCF};

      // Reset state and opcode sweep, one request per cycle.
      do_reset();
      got_q.delete();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vec[i].a, vec[i].b, vec[i].op, 1'b1);
         step();
      end
      drain("sweep drain");
      check("sweep count", 64'(got_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         check("sweep y", 64'(got_q[i][7:0]), 64'(vec[i].y));
         check("sweep op", 64'(got_q[i][9:8]), 64'(vec[i].op));
      end

      // Backpressure: consumer stalled, producer always valid.
      do_reset();
      acc_cnt = 0;
      got_q.delete();
      for (int i = 0; i < 8; i++) begin
         drive_rand(1'b1, 1'b0);
         step();
      end
      check("bp accepts", 64'(acc_cnt), 64'd4);
      check("bp in_ready low", 64'(bus.in_ready), 64'd0);
      drain("bp drain");
      check("bp drained", 64'(got_q.size()), 64'd4);

      // Streaming: 100 back-to-back requests.
      do_reset();
      acc_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         drive_rand(1'b1, 1'b1);
         step();
      end
      check("stream accepts", 64'(acc_cnt), 64'd100);
      drain("stream drain");
      check("stream resp_count", 64'(resp_count), 64'd100);

      // Random valid and ready on both sides.
      for (int i = 0; i < 300; i++) begin
         drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         step();
      end
      drain("random drain");

      // Preload two FIFO entries, then push and pop concurrently.
      for (int i = 0; i < 2; i++) begin
         drive_rand(1'b1, 1'b0);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drive_rand(1'b0, 1'b0);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         drive_rand(1'b1, 1'b1);
         step();
      end
      drain("pushpop drain");

      // Reset with three requests in flight; nothing stale may appear after.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1, 1'b1);
         step();
      end
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive_rand(1'b0, 1'b1);
         step();
      end

      // resp_count wrap after 65537 handshakes.
      do_reset();
      for (int i = 0; i < 65537; i++) begin
         drive_rand(1'b1, 1'b1);
         step();
      end
      drain("wrap drain");
      check("wrap resp_count", 64'(resp_count), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
